eth_pcs_rx_sync: RTL and testbench
==================================

# eth_pcs_rx_sync

Parametrised 64b/66b PCS receive synchroniser for the 10G/25G Ethernet PCS: takes header/payload words from the RX gearbox, runs the block-lock state machine, and drives a bit-slip request back to the gearbox. It descrambles the payload with the self-synchronising x^58+x^39+1 polynomial and monitors header bit-error rate. It sits between `eth_pcs_rx_gearbox` and `eth_pcs_66_64_decoder`. It supports 32- or 64-bit datapaths and configurable lock and BER thresholds.

## Interface
- W_DATA, 64, payload word width; legal values 32 (two words per 66b block) or 64 (one word per block)
- W_SYNC, 2, sync header width
- LOCK_CNT, 64, consecutive valid headers required to declare lock
- WIN_SH, 64, headers per invalid-header test window while locked
- BAD_SH_MAX, 16, invalid headers in one window that force loss of lock
- SLIP_WAIT, 4, cycles after a slip during which headers are ignored
- BER_WIN, 19531, BER window length in i_clk cycles (125 us at 156.25 MHz)
- BER_BAD, 16, invalid headers in one BER window that set hi_ber

- i_clk  in  1  clock
- i_reset  in  1  asynchronous, active-high reset
- i_hdr_valid  in  1  i_hdr valid; coincides with the first payload word of a block
- i_hdr  in  W_SYNC  sync header; 2'b01 and 2'b10 are valid
- i_data_valid  in  1  i_data valid (gearbox clock enable)
- i_data  in  W_DATA  scrambled payload, bit 0 first on the wire
- i_ber_clr  in  1  one-cycle pulse that clears o_ber_cnt
- o_slip  out  1  one-cycle bit-slip request to the gearbox
- o_block_lock  out  1  block lock achieved
- o_hi_ber  out  1  high bit-error-rate indication
- o_ber_cnt  out  6  saturating invalid-header count
- o_valid  out  1  o_data valid
- o_hdr_valid  out  1  o_hdr valid
- o_hdr  out  W_SYNC  registered header
- o_data  out  W_DATA  descrambled payload

## Operation
- Header evaluation happens only when i_data_valid && i_hdr_valid; a header is bad when it is 2'b00 or 2'b11.
- Lock FSM has three states: HUNT, SLIP_WT, LOCKED. Reset state is HUNT.
  - HUNT: a good header increments sh_cnt. When sh_cnt reaches LOCK_CNT, go to LOCKED, set o_block_lock, and clear the counters.
  - HUNT: a bad header pulses o_slip, clears sh_cnt, and goes to SLIP_WT.
  - SLIP_WT: the FSM ignores headers for SLIP_WAIT cycles (free-running cycles, not valid beats), then returns to HUNT.
  - LOCKED: every evaluated header increments sh_cnt; bad headers also increment bad_cnt.
  - LOCKED: if bad_cnt reaches BAD_SH_MAX, pulse o_slip, clear o_block_lock, clear the counters, and go to SLIP_WT.
  - LOCKED: otherwise, when sh_cnt reaches WIN_SH, clear both counters and stay in LOCKED.
  - If the last header of a window is also the BAD_SH_MAX-th bad header, loss of lock wins.
- Descrambler: 58-bit shift register s, reset value 0, advances only on i_data_valid.
  - For bit i in ascending order: out[i] = in[i] ^ s[38] ^ s[57], then s = {s[56:0], in[i]}.
  - The register shifts in scrambled input bits, so the descrambler recovers within 58 bits.
  - The header is never descrambled.
- o_ber_cnt increments on every bad header in any lock state and saturates at 63.
  - i_ber_clr clears it.
  - If a clear and an increment land in the same cycle, the result is 1.
- BER monitor runs only while o_block_lock = 1.
  - A cycle timer counts 0..BER_WIN-1 and wraps; bad headers increment ber_bad, which saturates at BER_BAD.
  - When ber_bad reaches BER_BAD, set o_hi_ber immediately.
  - At timer wrap, if ber_bad < BER_BAD, clear o_hi_ber. Either way, clear ber_bad.
  - On loss of lock, reset the timer and ber_bad; o_hi_ber holds its value.

## Timing
- All outputs reset to 0; all internal counters and s reset to 0.
- o_valid, o_hdr_valid, o_hdr and o_data have 1-cycle latency from i_data_valid.
  - Output registers update only when i_data_valid = 1.
  - o_valid is 1 exactly in the cycle after i_data_valid.
- o_slip and the o_block_lock transitions are registered: they are seen the cycle after the deciding header is sampled.
- o_slip is never high on two consecutive cycles.
- An asynchronous reset mid-block returns the FSM to HUNT and clears lock immediately; the first post-reset header starts a fresh count.
- W_DATA=32: headers arrive on alternate valid words.
  - The descrambler treats both words as one continuous bit stream.
  - i_hdr_valid on two consecutive valid words is treated as the gearbox resynchronising, and the second header is evaluated normally.

## Configuration
- ETH_PCS_RX_HI_BER_EN: when defined, the BER monitor (timer, ber_bad, o_hi_ber) is built.
- When not defined, o_hi_ber is tied to 0 and no BER timer logic exists.
- o_ber_cnt and the lock FSM behave the same either way.

## Test plan
- 64 consecutive 2'b01 headers after reset -> o_block_lock rises on the cycle after the 64th valid header; o_slip stays 0.
- In HUNT, header 2'b11 after 10 good headers -> o_slip high for exactly 1 cycle; no header is evaluated for 4 cycles; lock needs 64 new good headers.
- Locked, 15 bad headers in a 64-header window -> lock holds and counters clear. Then 16 bad headers in the next window -> o_slip pulses and o_block_lock falls on the 16th.
- Scrambled idle stream (a known scrambler output of all-zero payload) -> after the first 58 bits o_data = 0 on every valid word; o_data lags i_data by 1 cycle.
- With ETH_PCS_RX_HI_BER_EN and BER_WIN=100, 16 bad headers within 100 cycles while locked -> o_hi_ber = 1. A following window with 0 bad headers -> o_hi_ber = 0 at wrap. Without the macro, o_hi_ber stays 0.
- 70 bad headers -> o_ber_cnt = 63. i_ber_clr coinciding with a bad header -> o_ber_cnt = 1.

Source files
------------

// File: rtl/eth_pcs_rx_sync.sv
// rtl/eth_pcs_rx_sync.sv - 64b/66b PCS RX block lock, descrambler and header BER monitor
// Optional BER monitor (timer, ber_bad, o_hi_ber) is built when ETH_PCS_RX_HI_BER_EN is defined.
module eth_pcs_rx_sync #(
  parameter int W_DATA     = 64,
  parameter int W_SYNC     = 2,
  parameter int LOCK_CNT   = 64,
  parameter int WIN_SH     = 64,
  parameter int BAD_SH_MAX = 16,
  parameter int SLIP_WAIT  = 4,
  parameter int BER_WIN    = 19531,
  parameter int BER_BAD    = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_hdr_valid,
  input  logic [W_SYNC-1:0] i_hdr,
  input  logic              i_data_valid,
  input  logic [W_DATA-1:0] i_data,
  input  logic              i_ber_clr,
  output logic              o_slip,
  output logic              o_block_lock,
  output logic              o_hi_ber,
  output logic [5:0]        o_ber_cnt,
  output logic              o_valid,
  output logic              o_hdr_valid,
  output logic [W_SYNC-1:0] o_hdr,
  output logic [W_DATA-1:0] o_data
);

  localparam int CNT_MAX = (LOCK_CNT > WIN_SH) ? LOCK_CNT : WIN_SH;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int BW = $clog2(BAD_SH_MAX + 1);
  localparam int WW = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CNT - 1);
  localparam logic [CW-1:0] WIN_LAST  = CW'(WIN_SH - 1);
  localparam logic [BW-1:0] BAD_LAST  = BW'(BAD_SH_MAX - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(SLIP_WAIT - 1);

  if (!(W_DATA == 32 || W_DATA == 64) || SLIP_WAIT < 1 || BAD_SH_MAX < 1 ||
      BER_WIN < 2 || BER_BAD < 1) begin : g_bad_params
    $error("eth_pcs_rx_sync: illegal parameter value");
  end

  typedef enum logic [1:0] {HUNT, SLIP_WT, LOCKED} state_t;

  state_t        state;
  logic [CW-1:0] sh_cnt;
  logic [BW-1:0] bad_cnt;
  logic [WW-1:0] wait_cnt;
  logic          hdr_seen;
  logic          hdr_bad;

  assign hdr_seen = i_data_valid & i_hdr_valid;
  // A sync header is valid only when its bits differ (01 or 10).
  assign hdr_bad  = hdr_seen & ~(^i_hdr);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= HUNT;
      sh_cnt       <= '0;
      bad_cnt      <= '0;
      wait_cnt     <= '0;
      o_slip       <= 1'b0;
      o_block_lock <= 1'b0;
    end else begin
      o_slip <= 1'b0;
      case (state)
        HUNT: begin
          if (hdr_seen) begin
            if (hdr_bad) begin
              o_slip   <= 1'b1;
              sh_cnt   <= '0;
              wait_cnt <= '0;
              state    <= SLIP_WT;
            end else if (sh_cnt == LOCK_LAST) begin
              o_block_lock <= 1'b1;
              sh_cnt       <= '0;
              bad_cnt      <= '0;
              state        <= LOCKED;
            end else begin
              sh_cnt <= sh_cnt + 1'b1;
            end
          end
        end
        SLIP_WT: begin
          if (wait_cnt == WAIT_LAST) state <= HUNT;
          else                       wait_cnt <= wait_cnt + 1'b1;
        end
        LOCKED: begin
          if (hdr_seen) begin
            // Loss of lock is checked first so it wins on the last header of a window.
            if (hdr_bad && bad_cnt == BAD_LAST) begin
              o_slip       <= 1'b1;
              o_block_lock <= 1'b0;
              sh_cnt       <= '0;
              bad_cnt      <= '0;
              wait_cnt     <= '0;
              state        <= SLIP_WT;
            end else if (sh_cnt == WIN_LAST) begin
              sh_cnt  <= '0;
              bad_cnt <= '0;
            end else begin
              sh_cnt  <= sh_cnt + 1'b1;
              bad_cnt <= bad_cnt + BW'(hdr_bad);
            end
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

  logic [57:0]       scr;
  logic [57:0]       scr_nxt;
  logic [W_DATA-1:0] dsc;

  // Self-synchronising descrambler: the history holds received (scrambled) bits.
  always_comb begin
    scr_nxt = scr;
    dsc     = '0;
    for (int i = 0; i < W_DATA; i++) begin
      dsc[i]  = i_data[i] ^ scr_nxt[38] ^ scr_nxt[57];
      scr_nxt = {scr_nxt[56:0], i_data[i]};
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      scr         <= '0;
      o_valid     <= 1'b0;
      o_hdr_valid <= 1'b0;
      o_hdr       <= '0;
      o_data      <= '0;
    end else begin
      o_valid <= i_data_valid;
      if (i_data_valid) begin
        scr         <= scr_nxt;
        o_hdr_valid <= i_hdr_valid;
        o_hdr       <= i_hdr;
        o_data      <= dsc;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                             o_ber_cnt <= '0;
    else if (i_ber_clr)                      o_ber_cnt <= {5'd0, hdr_bad};
    else if (hdr_bad && o_ber_cnt != 6'd63) o_ber_cnt <= o_ber_cnt + 6'd1;
  end

`ifdef ETH_PCS_RX_HI_BER_EN
  localparam int TW = $clog2(BER_WIN);
  localparam int RW = $clog2(BER_BAD + 1);
  localparam logic [TW-1:0] TMR_LAST  = TW'(BER_WIN - 1);
  localparam logic [RW-1:0] BER_LIMIT = RW'(BER_BAD);

  logic [TW-1:0] ber_tmr;
  logic [RW-1:0] ber_bad;
  logic [RW-1:0] ber_bad_nxt;

  always_comb begin
    ber_bad_nxt = ber_bad;
    if (hdr_bad && ber_bad != BER_LIMIT) ber_bad_nxt = ber_bad + 1'b1;
  end

  // o_hi_ber deliberately holds across loss of lock; only a clean window clears it.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ber_tmr  <= '0;
      ber_bad  <= '0;
      o_hi_ber <= 1'b0;
    end else if (!o_block_lock) begin
      ber_tmr <= '0;
      ber_bad <= '0;
    end else begin
      if (ber_bad_nxt == BER_LIMIT) o_hi_ber <= 1'b1;
      if (ber_tmr == TMR_LAST) begin
        ber_tmr <= '0;
        ber_bad <= '0;
        if (ber_bad_nxt != BER_LIMIT) o_hi_ber <= 1'b0;
      end else begin
        ber_tmr <= ber_tmr + 1'b1;
        ber_bad <= ber_bad_nxt;
      end
    end
  end
`else
  assign o_hi_ber = 1'b0;
`endif

endmodule

// File: tb/tb_eth_pcs_rx_sync.sv
// tb/tb_eth_pcs_rx_sync.sv - self-checking bench for eth_pcs_rx_sync (64-bit datapath, BER_WIN=100)
module tb_eth_pcs_rx_sync;

  localparam int W_DATA = 64;
`ifdef ETH_PCS_RX_HI_BER_EN
  localparam bit HI_EN = 1'b1;
`else
  localparam bit HI_EN = 1'b0;
`endif

  logic              i_clk = 1'b0;
  logic              i_reset = 1'b1;
  logic              i_hdr_valid = 1'b0;
  logic [1:0]        i_hdr = 2'b00;
  logic              i_data_valid = 1'b0;
  logic [W_DATA-1:0] i_data = '0;
  logic              i_ber_clr = 1'b0;
  logic              o_slip, o_block_lock, o_hi_ber, o_valid, o_hdr_valid;
  logic [5:0]        o_ber_cnt;
  logic [1:0]        o_hdr;
  logic [W_DATA-1:0] o_data;

  eth_pcs_rx_sync #(.W_DATA(W_DATA), .BER_WIN(100)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_hdr_valid(i_hdr_valid), .i_hdr(i_hdr),
    .i_data_valid(i_data_valid), .i_data(i_data), .i_ber_clr(i_ber_clr),
    .o_slip(o_slip), .o_block_lock(o_block_lock), .o_hi_ber(o_hi_ber),
    .o_ber_cnt(o_ber_cnt), .o_valid(o_valid), .o_hdr_valid(o_hdr_valid),
    .o_hdr(o_hdr), .o_data(o_data)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: header-count rules indexed by cycle number since reset.
  int   cyc, words, m_cnt, m_bad, m_ber, m_block_until;
  bit   m_lock, m_slip, chk_model;
  logic [57:0] tx_s;

  task automatic model_reset();
    cyc = 0; words = 0; m_cnt = 0; m_bad = 0; m_ber = 0; m_block_until = -1;
    m_lock = 0; m_slip = 0;
  endtask

  task automatic model_step(input logic dv, input logic hv, input logic [1:0] h, input logic clr);
    bit seen, bad;
    cyc++;
    m_slip = 0;
    seen = dv && hv;
    bad  = seen && (h == 2'b00 || h == 2'b11);
    if (clr) m_ber = bad ? 1 : 0;
    else if (bad && m_ber < 63) m_ber++;
    if (seen && cyc > m_block_until) begin
      if (!m_lock) begin
        if (bad) begin
          m_slip = 1; m_cnt = 0; m_block_until = cyc + 4;
        end else begin
          m_cnt++;
          if (m_cnt == 64) begin m_lock = 1; m_cnt = 0; m_bad = 0; end
        end
      end else begin
        m_cnt++;
        if (bad) m_bad++;
        if (m_bad == 16) begin
          m_slip = 1; m_lock = 0; m_cnt = 0; m_bad = 0; m_block_until = cyc + 4;
        end else if (m_cnt == 64) begin
          m_cnt = 0; m_bad = 0;
        end
      end
    end
  endtask

  // Transmit-side multiplicative scrambler, the inverse of the DUT's descrambler.
  task automatic scramble(input logic [63:0] p, output logic [63:0] s);
    for (int i = 0; i < 64; i++) begin
      s[i] = p[i] ^ tx_s[38] ^ tx_s[57];
      tx_s = {tx_s[56:0], s[i]};
    end
  endtask

  task automatic drive(input logic dv, input logic hv, input logic [1:0] h,
                       input logic clr, input logic zero_pay);
    logic [63:0] plain, sc;
    plain = zero_pay ? 64'd0 : {$urandom, $urandom};
    if (dv) scramble(plain, sc);
    else    sc = {$urandom, $urandom};
    i_data_valid = dv; i_hdr_valid = hv; i_hdr = h; i_ber_clr = clr; i_data = sc;
    model_step(dv, hv, h, clr);
    @(posedge i_clk); #1;
    if (dv) words++;
    if (chk_model) begin
      check("slip", 64'(o_slip), 64'(m_slip));
      check("block_lock", 64'(o_block_lock), 64'(m_lock));
      check("ber_cnt", 64'(o_ber_cnt), 64'(m_ber));
      check("valid", 64'(o_valid), 64'(dv));
      if (dv) begin
        check("hdr", 64'(o_hdr), 64'(h));
        check("hdr_valid", 64'(o_hdr_valid), 64'(hv));
        if (words >= 2) check("data", o_data, plain);
      end
      if (!HI_EN) check("hi_ber_off", 64'(o_hi_ber), 64'd0);
    end
  endtask

  task automatic hdr(input logic [1:0] h);
    drive(1'b1, 1'b1, h, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    i_reset = 1'b1; i_data_valid = 0; i_hdr_valid = 0; i_ber_clr = 0;
    repeat (2) @(posedge i_clk);
    #1 i_reset = 1'b0;
    model_reset();
  endtask

  // Lock from HUNT with 64 good headers; checks the 63rd and 64th.
  task automatic relock(input string tag);
    for (int i = 0; i < 63; i++) hdr(2'b01);
    check({tag, "_lock63"}, 64'(o_block_lock), 64'd0);
    hdr(2'b10);
    check({tag, "_lock64"}, 64'(o_block_lock), 64'd1);
  endtask

  typedef struct {
    logic dv; logic hv; logic [1:0] h; logic clr;
    logic e_slip; logic e_lock; logic [5:0] e_cnt;
  } vec_t;
  vec_t tbl[10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit flag_a, flag_b, prev;
    int nslip;
    tx_s = 58'({$urandom, $urandom});
    chk_model = 0;
    model_reset();

    // Edges counted from reset release; slip at edge 3 blocks edges 4..7.
    tbl[0] = '{1, 1, 2'b01, 0, 0, 0, 6'd0};
    tbl[1] = '{1, 1, 2'b10, 0, 0, 0, 6'd0};
    tbl[2] = '{1, 1, 2'b11, 0, 1, 0, 6'd1};
    tbl[3] = '{1, 1, 2'b00, 0, 0, 0, 6'd2};
    tbl[4] = '{0, 1, 2'b00, 0, 0, 0, 6'd2};
    tbl[5] = '{1, 0, 2'b11, 0, 0, 0, 6'd2};
    tbl[6] = '{1, 1, 2'b01, 0, 0, 0, 6'd2};
    tbl[7] = '{1, 1, 2'b00, 0, 1, 0, 6'd3};
    tbl[8] = '{1, 1, 2'b11, 1, 0, 0, 6'd1};
    tbl[9] = '{0, 0, 2'b01, 1, 0, 0, 6'd0};

    #1;
    check("rst_slip", 64'(o_slip), 64'd0);
    check("rst_lock", 64'(o_block_lock), 64'd0);
    check("rst_hi_ber", 64'(o_hi_ber), 64'd0);
    check("rst_ber_cnt", 64'(o_ber_cnt), 64'd0);
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_hdr_valid", 64'(o_hdr_valid), 64'd0);
    check("rst_hdr", 64'(o_hdr), 64'd0);
    check("rst_data", o_data, 64'd0);

    // Plain lock acquisition
    do_reset();
    flag_a = 0;
    for (int i = 0; i < 63; i++) begin hdr(2'b01); flag_a |= o_slip; end
    check("acq_lock63", 64'(o_block_lock), 64'd0);
    hdr(2'b01);
    check("acq_lock64", 64'(o_block_lock), 64'd1);
    check("acq_no_slip", 64'(flag_a), 64'd0);

    // Table: slip, hold-off, ber_cnt clear/increment collision
    do_reset();
    for (int k = 0; k < 10; k++) begin
      drive(tbl[k].dv, tbl[k].hv, tbl[k].h, tbl[k].clr, 1'b0);
      check($sformatf("tbl%0d_slip", k), 64'(o_slip), 64'(tbl[k].e_slip));
      check($sformatf("tbl%0d_lock", k), 64'(o_block_lock), 64'(tbl[k].e_lock));
      check($sformatf("tbl%0d_ber_cnt", k), 64'(o_ber_cnt), 64'(tbl[k].e_cnt));
      check($sformatf("tbl%0d_valid", k), 64'(o_valid), 64'(tbl[k].dv));
    end
    idle(4);
    relock("hunt");

    // Locked: 15 bad in a window holds, 16 bad drops lock
    flag_a = 0; flag_b = 0;
    for (int i = 0; i < 64; i++) begin
      hdr((i < 60 && i % 4 == 0) ? 2'b00 : 2'b01);
      flag_a |= ~o_block_lock; flag_b |= o_slip;
    end
    check("win15_lock_drop", 64'(flag_a), 64'd0);
    check("win15_slip", 64'(flag_b), 64'd0);
    for (int i = 0; i < 15; i++) hdr(2'b11);
    check("win16_lock_at15", 64'(o_block_lock), 64'd1);
    hdr(2'b00);
    check("win16_slip", 64'(o_slip), 64'd1);
    check("win16_lock", 64'(o_block_lock), 64'd0);
    idle(1);
    check("win16_slip_1cyc", 64'(o_slip), 64'd0);
    idle(3);
    relock("re1");
    // 16th bad header is also the window's last header
    for (int i = 0; i < 48; i++) hdr(2'b01);
    for (int i = 0; i < 15; i++) hdr(2'b00);
    check("edge_lock_at63", 64'(o_block_lock), 64'd1);
    hdr(2'b11);
    check("edge_lock_lost", 64'(o_block_lock), 64'd0);
    check("edge_slip", 64'(o_slip), 64'd1);
    idle(4);
    relock("re2");

    // Asynchronous reset in mid-cycle while locked
    for (int i = 0; i < 40; i++) hdr(2'b01);
    #3 i_reset = 1'b1;
    #1;
    check("async_lock", 64'(o_block_lock), 64'd0);
    check("async_ber_cnt", 64'(o_ber_cnt), 64'd0);
    #1 i_reset = 1'b0;
    model_reset();
    relock("post_rst");

    // BER monitor: lock rose at edge L; bad at L+1..L+10 and L+65..L+70
    for (int i = 1; i <= 205; i++) begin
      hdr(((i <= 10) || (i >= 65 && i <= 70)) ? 2'b00 : 2'b01);
      if (i == 69)  check("ber_hi_at15", 64'(o_hi_ber), 64'd0);
      if (i == 70) begin
        check("ber_hi_at16", 64'(o_hi_ber), 64'(HI_EN));
        check("ber_cnt16", 64'(o_ber_cnt), 64'd16);
      end
      if (i == 190) check("ber_hi_hold", 64'(o_hi_ber), 64'(HI_EN));
    end
    check("ber_hi_cleared", 64'(o_hi_ber), 64'd0);
    check("ber_lock_held", 64'(o_block_lock), 64'd1);

    // ber_cnt saturation and slip spacing
    do_reset();
    nslip = 0; prev = 0; flag_a = 0;
    for (int i = 1; i <= 70; i++) begin
      hdr(2'b00);
      if (o_slip) nslip++;
      flag_a |= prev & o_slip;
      prev = o_slip;
      if (i == 62) check("sat_cnt62", 64'(o_ber_cnt), 64'd62);
    end
    check("sat_cnt70", 64'(o_ber_cnt), 64'd63);
    check("sat_slip_count", 64'(nslip), 64'd14);
    check("sat_slip_b2b", 64'(flag_a), 64'd0);
    drive(1'b1, 1'b1, 2'b11, 1'b1, 1'b0);
    check("clr_with_bad", 64'(o_ber_cnt), 64'd1);
    drive(1'b0, 1'b0, 2'b01, 1'b1, 1'b0);
    check("clr_only", 64'(o_ber_cnt), 64'd0);

    // Scrambled idle stream with gaps
    do_reset();
    chk_model = 1;
    for (int i = 0; i < 60; i++) begin
      logic dv;
      dv = (i < 2) || ($urandom_range(0, 2) != 0);
      drive(dv, dv, 2'b01, 1'b0, 1'b1);
      if (dv && words >= 2) check("idle_data_zero", o_data, 64'd0);
    end

    // Randomised run against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      logic dv, hv, clr;
      logic [1:0] h;
      int den;
      den = (i % 1000 < 700) ? 64 : 3;
      dv  = ($urandom_range(0, 7) != 0);
      hv  = ($urandom_range(0, 15) != 0);
      clr = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, den - 1) == 0) h = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
      else                                 h = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
      drive(dv, hv, h, clr, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
